unidade_controle_es: RTL and testbench

- Parametrised successor to the single-cycle CatCORE control decoder.
- Decodes the 6-bit opcode into the datapath control word, as the current decoder does.
- Adds a clocked I/O/HALT state machine. INPUT, OUTPUT and HALT now stall the PC until a synchronised, edge-detected `enter` press.
- Sits between the instruction memory output and the datapath muxes, ALU, register bank and data memory.

---
 rtl/catcore_ctrl_pkg.sv | 119 +++++++++++
 rtl/unidade_controle_es_if.sv | 45 ++++
 rtl/sincronizador_enter.sv | 28 ++
 rtl/unidade_controle_es.sv | 115 +++++++++++
 tb/tb_unidade_controle_es.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/catcore_ctrl_pkg.sv
// catcore_ctrl_pkg: opcodes, ALU codes, mux selects and FSM states of the CatCORE control unit.
`default_nettype none
package catcore_ctrl_pkg;

  localparam logic [5:0] OP_NOP    = 6'b000000;
  localparam logic [5:0] OP_ADD    = 6'b100000;
  localparam logic [5:0] OP_SUB    = 6'b100001;
  localparam logic [5:0] OP_MULT   = 6'b101010;
  localparam logic [5:0] OP_DIV    = 6'b101011;
  localparam logic [5:0] OP_SMLEQ  = 6'b100100;
  localparam logic [5:0] OP_SML    = 6'b100101;
  localparam logic [5:0] OP_LGREQ  = 6'b100110;
  localparam logic [5:0] OP_LGR    = 6'b100111;
  localparam logic [5:0] OP_EQ     = 6'b101110;
  localparam logic [5:0] OP_MOV    = 6'b010100;
  localparam logic [5:0] OP_ADDI   = 6'b010000;
  localparam logic [5:0] OP_SUBI   = 6'b010001;
  localparam logic [5:0] OP_LW     = 6'b011111;
  localparam logic [5:0] OP_LWR    = 6'b011101;
  localparam logic [5:0] OP_SW     = 6'b011110;
  localparam logic [5:0] OP_SWR    = 6'b011100;
  localparam logic [5:0] OP_LOADI  = 6'b011001;
  localparam logic [5:0] OP_JUMP   = 6'b111111;
  localparam logic [5:0] OP_BNE    = 6'b010111;
  localparam logic [5:0] OP_JR     = 6'b011010;
  localparam logic [5:0] OP_JAL    = 6'b011000;
  localparam logic [5:0] OP_INPUT  = 6'b000111;
  localparam logic [5:0] OP_OUTPUT = 6'b111000;
  localparam logic [5:0] OP_HALT   = 6'b111110;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_MOV   = 4'b0100;
  localparam logic [3:0] ALU_SML   = 4'b0110;
  localparam logic [3:0] ALU_MULT  = 4'b1000;
  localparam logic [3:0] ALU_DIV   = 4'b1001;
  localparam logic [3:0] ALU_LGR   = 4'b1010;
  localparam logic [3:0] ALU_SMLEQ = 4'b1011;
  localparam logic [3:0] ALU_LGREQ = 4'b1100;
  localparam logic [3:0] ALU_EQ    = 4'b1101;

  localparam logic [2:0] PC_INC    = 3'b000;
  localparam logic [2:0] PC_BRANCH = 3'b010;
  localparam logic [2:0] PC_JUMP   = 3'b011;
  localparam logic [2:0] PC_REG    = 3'b100;

  localparam logic [1:0] WB_ALU    = 2'b00;
  localparam logic [1:0] WB_MEM    = 2'b01;
  localparam logic [1:0] WB_IMM    = 2'b10;
  localparam logic [1:0] WB_IN     = 2'b11;

  localparam logic [1:0] MN_STORE  = 2'b01;

  localparam logic [1:0] S_RUN      = 2'b00;
  localparam logic [1:0] S_WAIT_IN  = 2'b01;
  localparam logic [1:0] S_WAIT_OUT = 2'b10;
  localparam logic [1:0] S_HALTED   = 2'b11;

  typedef struct packed {
    logic [2:0] mux4;
    logic [1:0] mux3;
    logic [1:0] muxn;
    logic [3:0] alu;
    logic       mux2;
    logic       escrita_br;
    logic       d2;
    logic       escrita_mem;
    logic       opt;
    logic       jal;
    logic       halt;
  } ctrl_t;

  function automatic logic op_listed(input logic [5:0] op);
    return op inside {OP_NOP, OP_ADD, OP_SUB, OP_MULT, OP_DIV, OP_SMLEQ, OP_SML,
                      OP_LGREQ, OP_LGR, OP_EQ, OP_MOV, OP_ADDI, OP_SUBI, OP_LW,
                      OP_LWR, OP_SW, OP_SWR, OP_LOADI, OP_JUMP, OP_BNE, OP_JR,
                      OP_JAL, OP_INPUT, OP_OUTPUT, OP_HALT};
  endfunction

  // Run-state control word; the I/O and HALT opcodes are handled by the FSM.
  function automatic ctrl_t decode_op(input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_ADD, OP_ADDI:          c.alu = ALU_ADD;
      OP_SUB, OP_SUBI, OP_BNE:  c.alu = ALU_SUB;
      OP_MULT:                  c.alu = ALU_MULT;
      OP_DIV:                   c.alu = ALU_DIV;
      OP_SMLEQ:                 c.alu = ALU_SMLEQ;
      OP_SML:                   c.alu = ALU_SML;
      OP_LGREQ:                 c.alu = ALU_LGREQ;
      OP_LGR:                   c.alu = ALU_LGR;
      OP_EQ:                    c.alu = ALU_EQ;
      OP_MOV, OP_JAL:           c.alu = ALU_MOV;
      default:                  c.alu = ALU_ADD;
    endcase
    if (op inside {OP_ADD, OP_SUB, OP_MULT, OP_DIV, OP_SMLEQ, OP_SML,
                   OP_LGREQ, OP_LGR, OP_EQ, OP_MOV}) begin
      c.escrita_br = 1'b1;
      c.d2         = 1'b1;
    end
    case (op)
      OP_ADDI, OP_SUBI: begin c.mux2 = 1'b1; c.escrita_br = 1'b1; end
      OP_LW:    begin c.mux3 = WB_MEM; c.mux2 = 1'b1; c.escrita_br = 1'b1; end
      OP_LWR:   begin c.mux3 = WB_MEM; c.d2 = 1'b1; c.escrita_br = 1'b1; end
      OP_SW:    begin c.muxn = MN_STORE; c.mux2 = 1'b1; c.escrita_mem = 1'b1; end
      OP_SWR:   begin c.muxn = MN_STORE; c.d2 = 1'b1; c.escrita_mem = 1'b1; end
      OP_LOADI: begin c.mux3 = WB_IMM; c.escrita_br = 1'b1; end
      OP_JUMP:  c.mux4 = PC_JUMP;
      OP_BNE:   c.mux4 = PC_BRANCH;
      OP_JR:    c.mux4 = PC_REG;
      OP_JAL:   begin c.mux4 = PC_JUMP; c.d2 = 1'b1; c.escrita_mem = 1'b1; c.jal = 1'b1; end
      default:  c.mux4 = PC_INC;
    endcase
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/unidade_controle_es_if.sv
// unidade_controle_es_if: opcode/enter inputs and control-word outputs of the control unit.
`default_nettype none
interface unidade_controle_es_if #(
  parameter int OPCODE_W = 6,
  parameter int ALU_OP_W = 4
);
  logic [OPCODE_W-1:0] opcode;
  logic                enter;
  logic [2:0]          controle_MUX4;
  logic [1:0]          controle_MUX3;
  logic [1:0]          controle_MUXN;
  logic [ALU_OP_W-1:0] controle_ALU;
  logic                controle_MUX2;
  logic                controle_escrita_BR;
  logic                controle_D2_BR;
  logic                controle_escrita_memdados;
  logic                controle_OPT;
  logic                controleJAL;
  logic                HALT;
  logic [1:0]          estado;
`ifdef ILLEGAL_OP_TRAP_EN
  logic                trap;
`endif

  modport master (
    output opcode, enter,
    input  controle_MUX4, controle_MUX3, controle_MUXN, controle_ALU, controle_MUX2,
           controle_escrita_BR, controle_D2_BR, controle_escrita_memdados,
           controle_OPT, controleJAL, HALT, estado
`ifdef ILLEGAL_OP_TRAP_EN
           , trap
`endif
  );

  modport slave (
    input  opcode, enter,
    output controle_MUX4, controle_MUX3, controle_MUXN, controle_ALU, controle_MUX2,
           controle_escrita_BR, controle_D2_BR, controle_escrita_memdados,
           controle_OPT, controleJAL, HALT, estado
`ifdef ILLEGAL_OP_TRAP_EN
           , trap
`endif
  );
endinterface
`default_nettype wire

// File: rtl/sincronizador_enter.sv
// sincronizador_enter: SYNC_STAGES-deep synchroniser for the enter button with a
// registered one-cycle rising-edge pulse (latency SYNC_STAGES+1 cycles).
`default_nettype none
module sincronizador_enter #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic enter,
  output logic enter_pulse
);
  // Extra top bit holds the previous synchronised level for edge detection.
  logic [SYNC_STAGES:0] sync_q;
  logic                 pulse_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-1:0], enter};
      pulse_q <= sync_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES];
    end
  end

  assign enter_pulse = pulse_q;
endmodule
`default_nettype wire

// File: rtl/unidade_controle_es.sv
// unidade_controle_es: CatCORE opcode decoder with an I/O/HALT stall FSM released by enter.
// Optional macro ILLEGAL_OP_TRAP_EN: unlisted opcodes halt and set a sticky trap flag.
`default_nettype none
module unidade_controle_es
  import catcore_ctrl_pkg::*;
#(
  parameter int OPCODE_W    = 6,
  parameter int ALU_OP_W    = 4,
  parameter int SYNC_STAGES = 2
) (
  input logic                  clock,
  input logic                  reset_n,
  unidade_controle_es_if.slave bus
);
  logic       enter_pulse;
  logic [1:0] estado_q, estado_d;
  logic       listed;
  logic [5:0] op6;
  ctrl_t      word;
`ifdef ILLEGAL_OP_TRAP_EN
  logic       trap_q, trap_d;
`endif

  sincronizador_enter #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clock       (clock),
    .reset_n     (reset_n),
    .enter       (bus.enter),
    .enter_pulse (enter_pulse)
  );

  assign op6    = bus.opcode[5:0];
  assign listed = ((bus.opcode >> 6) == OPCODE_W'(0)) && op_listed(op6);

  always_comb begin
    word     = '0;
    estado_d = estado_q;
`ifdef ILLEGAL_OP_TRAP_EN
    trap_d   = trap_q;
`endif
    case (estado_q)
      S_RUN: begin
        if (!listed) begin
`ifdef ILLEGAL_OP_TRAP_EN
          word.halt = 1'b1;
          estado_d  = S_HALTED;
          trap_d    = 1'b1;
`endif
        end else if (op6 == OP_INPUT) begin
          word.halt = 1'b1;
          estado_d  = S_WAIT_IN;
        end else if (op6 == OP_OUTPUT) begin
          word.halt = 1'b1;
          word.opt  = 1'b1;
          estado_d  = S_WAIT_OUT;
        end else if (op6 == OP_HALT) begin
          word.halt = 1'b1;
          estado_d  = S_HALTED;
        end else begin
          word = decode_op(op6);
        end
      end
      S_WAIT_IN: begin
        if (enter_pulse) begin
          word.mux3       = WB_IN;
          word.escrita_br = 1'b1;
          estado_d        = S_RUN;
        end else begin
          word.halt = 1'b1;
        end
      end
      S_WAIT_OUT: begin
        word.opt = 1'b1;
        if (enter_pulse) estado_d = S_RUN;
        else             word.halt = 1'b1;
      end
      default: begin
        if (enter_pulse) estado_d = S_RUN;
        else             word.halt = 1'b1;
      end
    endcase
    // Nothing decodes while reset is held, even though the state already reads S_RUN.
    if (!reset_n) word = '0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q <= S_RUN;
`ifdef ILLEGAL_OP_TRAP_EN
      trap_q   <= 1'b0;
`endif
    end else begin
      estado_q <= estado_d;
`ifdef ILLEGAL_OP_TRAP_EN
      trap_q   <= trap_d;
`endif
    end
  end

  assign bus.controle_MUX4             = word.mux4;
  assign bus.controle_MUX3             = word.mux3;
  assign bus.controle_MUXN             = word.muxn;
  assign bus.controle_ALU              = ALU_OP_W'(word.alu);
  assign bus.controle_MUX2             = word.mux2;
  assign bus.controle_escrita_BR       = word.escrita_br;
  assign bus.controle_D2_BR            = word.d2;
  assign bus.controle_escrita_memdados = word.escrita_mem;
  assign bus.controle_OPT              = word.opt;
  assign bus.controleJAL               = word.jal;
  assign bus.HALT                      = word.halt;
  assign bus.estado                    = estado_q;
`ifdef ILLEGAL_OP_TRAP_EN
  assign bus.trap                      = trap_q;
`endif
endmodule
`default_nettype wire

// File: tb/tb_unidade_controle_es.sv
// tb_unidade_controle_es: directed vectors with a scoreboard queue checked by a negedge monitor.
`default_nettype none
module tb_unidade_controle_es;
  typedef struct packed {
    logic [2:0] m4;
    logic [1:0] m3;
    logic [1:0] mn;
    logic [3:0] alu;
    logic       m2, br, d2, mem, opt, jal, halt;
    logic [1:0] st;
    logic       trap;
  } word_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic exp_trap = 1'b0;
  word_t exp_q[$];
  string name_q[$];
  logic  act_trap;

  unidade_controle_es_if #(.OPCODE_W(6), .ALU_OP_W(4)) bus ();

  unidade_controle_es #(.OPCODE_W(6), .ALU_OP_W(4), .SYNC_STAGES(2)) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

`ifdef ILLEGAL_OP_TRAP_EN
  assign act_trap = bus.trap;
`else
  assign act_trap = 1'b0;
`endif

  always #5 clk = ~clk;

  function automatic word_t mk(input logic [2:0] m4, input logic [1:0] m3, input logic [1:0] mn,
                               input logic [3:0] alu, input logic m2, input logic br, input logic d2,
                               input logic mem, input logic opt, input logic jal, input logic halt,
                               input logic [1:0] st);
    return {m4, m3, mn, alu, m2, br, d2, mem, opt, jal, halt, st, exp_trap};
  endfunction

  function automatic word_t hw(input logic [1:0] st);
    return mk(3'b000, 2'b00, 2'b00, 4'b0000, 0, 0, 0, 0, 0, 0, 1, st);
  endfunction

  function automatic word_t r3(input logic [3:0] alu);
    return mk(3'b000, 2'b00, 2'b00, alu, 0, 1, 1, 0, 0, 0, 0, 2'b00);
  endfunction

  function automatic word_t addi_w();
    return mk(3'b000, 2'b00, 2'b00, 4'b0000, 1, 1, 0, 0, 0, 0, 0, 2'b00);
  endfunction

  task automatic cyc(input logic rn, input logic [5:0] op, input logic en, input word_t e,
                     input string nm);
    @(posedge clk);
    #1;
    rst_n      = rn;
    bus.opcode = op;
    bus.enter  = en;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      word_t e, a;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {bus.controle_MUX4, bus.controle_MUX3, bus.controle_MUXN, bus.controle_ALU,
            bus.controle_MUX2, bus.controle_escrita_BR, bus.controle_D2_BR,
            bus.controle_escrita_memdados, bus.controle_OPT, bus.controleJAL, bus.HALT,
            bus.estado, act_trap};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got m4=%b m3=%b mn=%b alu=%b m2=%b br=%b d2=%b mem=%b opt=%b jal=%b halt=%b st=%b trap=%b, expected m4=%b m3=%b mn=%b alu=%b m2=%b br=%b d2=%b mem=%b opt=%b jal=%b halt=%b st=%b trap=%b",
                 nm, a.m4, a.m3, a.mn, a.alu, a.m2, a.br, a.d2, a.mem, a.opt, a.jal, a.halt, a.st, a.trap,
                 e.m4, e.m3, e.mn, e.alu, e.m2, e.br, e.d2, e.mem, e.opt, e.jal, e.halt, e.st, e.trap);
      end
    end
  end

  initial begin
    bus.opcode = 6'b100000;
    bus.enter  = 1'b0;

    cyc(0, 6'b100000, 0, '0, "reset_zero");
    cyc(0, 6'b100000, 0, '0, "reset_zero");

    cyc(1, 6'b100000, 0, r3(4'b0000), "ADD");
    cyc(1, 6'b100001, 0, r3(4'b0001), "SUB");
    cyc(1, 6'b101010, 0, r3(4'b1000), "MULT");
    cyc(1, 6'b101011, 0, r3(4'b1001), "DIV");
    cyc(1, 6'b100100, 0, r3(4'b1011), "SMLEQ");
    cyc(1, 6'b100101, 0, r3(4'b0110), "SML");
    cyc(1, 6'b100110, 0, r3(4'b1100), "LGREQ");
    cyc(1, 6'b100111, 0, r3(4'b1010), "LGR");
    cyc(1, 6'b101110, 0, r3(4'b1101), "EQ");
    cyc(1, 6'b010100, 0, r3(4'b0100), "MOV");
    cyc(1, 6'b010000, 0, addi_w(), "ADDI");
    cyc(1, 6'b010000, 0, addi_w(), "ADDI_hold");
    cyc(1, 6'b010001, 0, mk(3'b000, 2'b00, 2'b00, 4'b0001, 1, 1, 0, 0, 0, 0, 0, 2'b00), "SUBI");
    cyc(1, 6'b011111, 0, mk(3'b000, 2'b01, 2'b00, 4'b0000, 1, 1, 0, 0, 0, 0, 0, 2'b00), "LW");
    cyc(1, 6'b011101, 0, mk(3'b000, 2'b01, 2'b00, 4'b0000, 0, 1, 1, 0, 0, 0, 0, 2'b00), "LWR");
    cyc(1, 6'b011110, 0, mk(3'b000, 2'b00, 2'b01, 4'b0000, 1, 0, 0, 1, 0, 0, 0, 2'b00), "SW");
    cyc(1, 6'b011100, 0, mk(3'b000, 2'b00, 2'b01, 4'b0000, 0, 0, 1, 1, 0, 0, 0, 2'b00), "SWR");
    cyc(1, 6'b011001, 0, mk(3'b000, 2'b10, 2'b00, 4'b0000, 0, 1, 0, 0, 0, 0, 0, 2'b00), "LOADI");
    cyc(1, 6'b111111, 0, mk(3'b011, 2'b00, 2'b00, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 2'b00), "JUMP");
    cyc(1, 6'b010111, 0, mk(3'b010, 2'b00, 2'b00, 4'b0001, 0, 0, 0, 0, 0, 0, 0, 2'b00), "BNE");
    cyc(1, 6'b011010, 0, mk(3'b100, 2'b00, 2'b00, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 2'b00), "JR");
    cyc(1, 6'b011000, 0, mk(3'b011, 2'b00, 2'b00, 4'b0100, 0, 0, 1, 1, 0, 1, 0, 2'b00), "JAL");
    cyc(1, 6'b000000, 0, '0, "NOP");

    // INPUT: enter held 10 cycles, single write on the pulse
    cyc(1, 6'b000111, 0, hw(2'b00), "IN_entry");
    cyc(1, 6'b010000, 1, hw(2'b01), "IN_wait");
    cyc(1, 6'b010000, 1, hw(2'b01), "IN_wait");
    cyc(1, 6'b010000, 1, hw(2'b01), "IN_wait");
    cyc(1, 6'b010000, 1, mk(3'b000, 2'b11, 2'b00, 4'b0000, 0, 1, 0, 0, 0, 0, 0, 2'b01), "IN_write");
    for (int i = 0; i < 6; i++) cyc(1, 6'b010000, 1, addi_w(), "IN_after_hold");
    for (int i = 0; i < 4; i++) cyc(1, 6'b010000, 0, addi_w(), "ADDI_settle");

    // OUTPUT: a pulse landing on the entry cycle must not release
    cyc(1, 6'b010000, 1, addi_w(), "ADDI_pulse_run");
    cyc(1, 6'b010000, 1, addi_w(), "ADDI_pulse_run");
    cyc(1, 6'b010000, 1, addi_w(), "ADDI_pulse_run");
    cyc(1, 6'b111000, 1, mk(3'b000, 2'b00, 2'b00, 4'b0000, 0, 0, 0, 0, 1, 0, 1, 2'b00), "OUT_entry");
    for (int i = 0; i < 3; i++)
      cyc(1, 6'b010000, 0, mk(3'b000, 2'b00, 2'b00, 4'b0000, 0, 0, 0, 0, 1, 0, 1, 2'b10), "OUT_held");
    for (int i = 0; i < 3; i++)
      cyc(1, 6'b010000, 1, mk(3'b000, 2'b00, 2'b00, 4'b0000, 0, 0, 0, 0, 1, 0, 1, 2'b10), "OUT_held2");
    cyc(1, 6'b010000, 1, mk(3'b000, 2'b00, 2'b00, 4'b0000, 0, 0, 0, 0, 1, 0, 0, 2'b10), "OUT_release");
    for (int i = 0; i < 4; i++) cyc(1, 6'b010000, 0, addi_w(), "OUT_back_run");

    // HALT: opcode change while halted is ignored
    cyc(1, 6'b111110, 0, hw(2'b00), "HALT_entry");
    cyc(1, 6'b100001, 0, hw(2'b11), "HALT_held");
    for (int i = 0; i < 3; i++) cyc(1, 6'b100001, 1, hw(2'b11), "HALT_held");
    cyc(1, 6'b100001, 1, mk(3'b000, 2'b00, 2'b00, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 2'b11), "HALT_release");
    for (int i = 0; i < 4; i++) cyc(1, 6'b100001, 0, r3(4'b0001), "HALT_back_run");

    // reset in the middle of S_WAIT_IN
    cyc(1, 6'b000111, 0, hw(2'b00), "RST_in_entry");
    cyc(1, 6'b100000, 0, hw(2'b01), "RST_in_wait");
    cyc(0, 6'b100000, 0, '0, "RST_mid_wait");
    cyc(0, 6'b100000, 0, '0, "RST_mid_wait");
    cyc(1, 6'b100000, 0, r3(4'b0000), "RST_after_ADD");

`ifdef ILLEGAL_OP_TRAP_EN
    cyc(1, 6'b101111, 0, hw(2'b00), "TRAP_entry");
    exp_trap = 1'b1;
    for (int i = 0; i < 3; i++) cyc(1, 6'b000000, 1, hw(2'b11), "TRAP_held");
    cyc(1, 6'b000000, 1, mk(3'b000, 2'b00, 2'b00, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 2'b11), "TRAP_release");
    cyc(1, 6'b000000, 0, '0 | word_t'(1), "TRAP_sticky");
`else
    cyc(1, 6'b101111, 0, '0, "ILLEGAL_nop");
    cyc(1, 6'b101111, 0, '0, "ILLEGAL_nop");
`endif

    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
